// File: rtl/fft_pkg.sv
// Shared types and sizing helpers for the in-place radix-2 DIF FFT sequencer.
package fft_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int DEF_LOG2N  = 3;
  localparam int DEF_RD_LAT = 2;

  function automatic int stage_w(input int log2n);
    return $clog2(log2n + 1);
  endfunction

  function automatic int tw_w(input int log2n);
    return log2n - 1;
  endfunction

endpackage

// File: rtl/fft_ctrl_addr_gen.sv
// Butterfly address generator: maps (stage, butterfly index) to the two sample
// addresses and the twiddle ROM index. Purely combinational.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = DEF_LOG2N,
  localparam int SW = stage_w(LOG2N),
  localparam int KW = LOG2N - 1
) (
  input  logic [SW-1:0]    s_i,
  input  logic [KW-1:0]    k_i,
  output logic [LOG2N-1:0] addr_a_o,
  output logic [LOG2N-1:0] addr_b_o,
  output logic [KW-1:0]    tw_o
);

  logic [LOG2N-1:0] k_ext;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] low_mask;
  logic [LOG2N-1:0] p;

  always_comb begin
    k_ext    = LOG2N'(k_i);
    p        = LOG2N'(LOG2N - 1) - LOG2N'(s_i);
    span     = LOG2N'(1) << p;
    low_mask = span - LOG2N'(1);
    // Bits of k at and above the span position move up one place, leaving a 0 gap.
    addr_a_o = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
    addr_b_o = addr_a_o | span;
    tw_o     = (k_i & low_mask[KW-1:0]) << s_i;
  end

endmodule

// File: rtl/fft_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 DIF FFT with one shared
// butterfly. Optional output scale_en is built when FFT_CTRL_SCALE_EN is defined.
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N  = DEF_LOG2N,
  parameter int RD_LAT = DEF_RD_LAT,
  localparam int SW = stage_w(LOG2N),
  localparam int TW = tw_w(LOG2N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [TW-1:0]    tw_idx,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic [SW-1:0]    stage,
`ifdef FFT_CTRL_SCALE_EN
  output logic             scale_en,
`endif
  output state_e           state_dbg
);

  localparam int KW = LOG2N - 1;
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e         state_q, state_d;
  logic [SW-1:0]  s_q, s_d;
  logic [KW-1:0]  k_q, k_d;
  logic [DW-1:0]  dcnt_q, dcnt_d;

  logic             pipe_en_q [RD_LAT];
  logic [LOG2N-1:0] pipe_a_q  [RD_LAT];
  logic [LOG2N-1:0] pipe_b_q  [RD_LAT];

  logic [LOG2N-1:0] gen_a, gen_b;
  logic [TW-1:0]    gen_tw;

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .s_i      (s_q),
    .k_i      (k_q),
    .addr_a_o (gen_a),
    .addr_b_o (gen_b),
    .tw_o     (gen_tw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        k_d   = k_q + KW'(1);
        if (&k_q) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        busy   = 1'b1;
        dcnt_d = dcnt_q + DW'(1);
        // Hold off the next stage until every write of this stage has landed.
        if (dcnt_q == DW'(RD_LAT - 1)) begin
          k_d    = '0;
          dcnt_d = '0;
          if (s_q == SW'(LOG2N - 1)) begin
            state_d = DONE;
            s_d     = '0;
          end else begin
            state_d = RUN;
            s_d     = s_q + SW'(1);
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_addr_a = rd_en ? gen_a  : '0;
  assign rd_addr_b = rd_en ? gen_b  : '0;
  assign tw_idx    = rd_en ? gen_tw : '0;
  assign stage     = s_q;
  assign state_dbg = state_q;

  // Read-to-write delay line; cleared on reset so in-flight writes are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_en_q[i] <= 1'b0;
        pipe_a_q[i]  <= '0;
        pipe_b_q[i]  <= '0;
      end
    end else begin
      pipe_en_q[0] <= rd_en;
      pipe_a_q[0]  <= rd_addr_a;
      pipe_b_q[0]  <= rd_addr_b;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_en_q[i] <= pipe_en_q[i-1];
        pipe_a_q[i]  <= pipe_a_q[i-1];
        pipe_b_q[i]  <= pipe_b_q[i-1];
      end
    end
  end

  assign wr_en     = pipe_en_q[RD_LAT-1];
  assign wr_addr_a = pipe_a_q[RD_LAT-1];
  assign wr_addr_b = pipe_b_q[RD_LAT-1];

`ifdef FFT_CTRL_SCALE_EN
  assign scale_en = wr_en;
`endif

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: N=8 and N=4 instances checked cycle by cycle
// against a per-cycle expectation table built from the FFT schedule.
module tb_fft_ctrl;
  import fft_pkg::*;

  localparam int RL = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start4;

  // N=8 instance
  logic       busy, done, rd_en, wr_en;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_idx, stage;
  state_e     state_dbg;
  // N=4 instance
  logic       busy4, done4, rd_en4, wr_en4;
  logic [1:0] rd_a4, rd_b4, wr_a4, wr_b4, stage4;
  logic [0:0] tw4;
  state_e     state4;
`ifdef FFT_CTRL_SCALE_EN
  logic scale_en, scale4;
`endif

  fft_ctrl #(.LOG2N(3), .RD_LAT(RL)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .stage(stage),
`ifdef FFT_CTRL_SCALE_EN
    .scale_en(scale_en),
`endif
    .state_dbg(state_dbg)
  );

  fft_ctrl #(.LOG2N(2), .RD_LAT(RL)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
    .rd_en(rd_en4), .rd_addr_a(rd_a4), .rd_addr_b(rd_b4), .tw_idx(tw4),
    .wr_en(wr_en4), .wr_addr_a(wr_a4), .wr_addr_b(wr_b4), .stage(stage4),
`ifdef FFT_CTRL_SCALE_EN
    .scale_en(scale4),
`endif
    .state_dbg(state4)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int m_rd[128], m_wr[128], m_wa[128], m_wb[128], m_done[128], m_busy[128], m_stage[128];

  function automatic logic [31:0] pk(input logic [9:0] a, input logic [9:0] b, input logic [9:0] tw);
    return {2'b00, a, b, tw};
  endfunction

  task automatic model_clear();
    exp_q.delete();
    for (int c = 0; c < 128; c++) begin
      m_rd[c] = 0; m_wr[c] = 0; m_wa[c] = 0; m_wb[c] = 0;
      m_done[c] = 0; m_busy[c] = 0; m_stage[c] = 0;
    end
  endtask

  // Transform whose start is sampled at edge 'base'; stage s pairs sample j of
  // group g with its partner 'span' away, twiddle stride N/(2*span).
  task automatic model_add(input int base, input int l);
    int n, h, span, c0, c, g, j, a, b, tw;
    n = 1 << l;
    h = n / 2;
    for (int s = 0; s < l; s++) begin
      span = n >> (s + 1);
      c0 = base + 1 + s * (h + RL);
      for (int t = 0; t < h + RL; t++) begin
        m_busy[c0 + t]  = 1;
        m_stage[c0 + t] = s;
      end
      for (int k = 0; k < h; k++) begin
        g  = k / span;
        j  = k % span;
        a  = g * 2 * span + j;
        b  = a + span;
        tw = j * (n / (2 * span));
        c  = c0 + k;
        m_rd[c] = 1;
        exp_q.push_back(pk(10'(a), 10'(b), 10'(tw)));
        m_wr[c + RL] = 1;
        m_wa[c + RL] = a;
        m_wb[c + RL] = b;
      end
    end
    m_done[base + l * (h + RL) + 1] = 1;
  endtask

  task automatic model_truncate(input int rst_at);
    for (int c = rst_at + 1; c < 128; c++) begin
      m_rd[c] = 0; m_wr[c] = 0; m_wa[c] = 0; m_wb[c] = 0;
      m_done[c] = 0; m_busy[c] = 0; m_stage[c] = 0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; start4 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts the N=8 DUT (sampled at edge 0), then observes cycles 1..ncyc.
  // Extra start pulses land at cycles s1/s2/s3; rst is pulsed at cycle rst_at.
  task automatic run_obs(input string tag, input int ncyc, input int s1, input int s2,
                         input int s3, input int rst_at);
    logic [3:0]  exp_ctrl, got_ctrl;
    logic [31:0] exp_rd, got_rd;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = (c == s1) || (c == s2) || (c == s3);
      rst   = (c == rst_at);
      exp_ctrl = {m_rd[c] != 0, m_wr[c] != 0, m_done[c] != 0, m_busy[c] != 0};
      got_ctrl = {rd_en, wr_en, done, busy};
      n_cmp++;
      if (got_ctrl !== exp_ctrl) begin
        n_err++;
        $display("FAIL %s c=%0d ctrl{rd,wr,done,busy} got=%b exp=%b", tag, c, got_ctrl, exp_ctrl);
      end
      got_rd = pk(10'(rd_addr_a), 10'(rd_addr_b), 10'(tw_idx));
      exp_rd = 32'd0;
      if (m_rd[c] != 0 && exp_q.size() > 0) exp_rd = exp_q.pop_front();
      n_cmp++;
      if (got_rd !== exp_rd) begin
        n_err++;
        $display("FAIL %s c=%0d rd{a,b,tw} got=%h exp=%h", tag, c, got_rd, exp_rd);
      end
      n_cmp++;
      if ({10'(wr_addr_a), 10'(wr_addr_b)} !== {10'(m_wa[c]), 10'(m_wb[c])}) begin
        n_err++;
        $display("FAIL %s c=%0d wr_addr got=%0d,%0d exp=%0d,%0d", tag, c, wr_addr_a, wr_addr_b,
                 m_wa[c], m_wb[c]);
      end
      n_cmp++;
      if (4'(stage) !== 4'(m_stage[c])) begin
        n_err++;
        $display("FAIL %s c=%0d stage got=%0d exp=%0d", tag, c, stage, m_stage[c]);
      end
`ifdef FFT_CTRL_SCALE_EN
      n_cmp++;
      if (scale_en !== (m_wr[c] != 0)) begin
        n_err++;
        $display("FAIL %s c=%0d scale_en got=%b exp=%0d", tag, c, scale_en, m_wr[c]);
      end
`endif
      if (c == rst_at + 1) begin
        n_cmp++;
        if (state_dbg !== IDLE) begin
          n_err++;
          $display("FAIL %s c=%0d state_after_rst got=%0d exp=%0d", tag, c, state_dbg, IDLE);
        end
      end
    end
    start = 1'b0;
    rst   = 1'b0;
    if (rst_at > 0) exp_q.delete();
    n_cmp++;
    if (exp_q.size() != 0 || state_dbg !== IDLE) begin
      n_err++;
      $display("FAIL %s end reads_left=%0d state=%0d exp 0,%0d", tag, exp_q.size(), state_dbg, IDLE);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, rd_en, wr_en, rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b, stage} !== '0
          || state_dbg !== IDLE) begin
        n_err++;
        $display("FAIL reset_idle c=%0d busy=%b done=%b rd=%b wr=%b stage=%0d state=%0d exp all 0",
                 c, busy, done, rd_en, wr_en, stage, state_dbg);
      end
    end
  endtask

  task automatic test_n8();
    model_clear();
    model_add(0, 3);
    run_obs("n8", 22, -1, -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    model_clear();
    model_add(0, 3);
    model_add(20, 3);
    run_obs("restart", 42, 5, 19, 20, -1);
  endtask

  task automatic test_rst_mid();
    model_clear();
    model_add(0, 3);
    model_truncate(8);
    run_obs("rst_mid", 12, -1, -1, -1, 8);
    model_clear();
    model_add(0, 3);
    run_obs("after_rst", 22, -1, -1, -1, -1);
  endtask

  task automatic test_random();
    int s1, s2;
    for (int it = 0; it < 4; it++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      s1 = $urandom_range(1, 19);
      s2 = $urandom_range(1, 19);
      model_clear();
      model_add(0, 3);
      run_obs("random", 22, s1, s2, -1, -1);
    end
  endtask

  task automatic test_n4();
    logic [3:0]  exp_ctrl;
    logic [31:0] exp_rd, got_rd;
    model_clear();
    model_add(0, 2);
    @(negedge clk);
    start4 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start4 = 1'b0;
      exp_ctrl = {m_rd[c] != 0, m_wr[c] != 0, m_done[c] != 0, m_busy[c] != 0};
      n_cmp++;
      if ({rd_en4, wr_en4, done4, busy4} !== exp_ctrl) begin
        n_err++;
        $display("FAIL n4 c=%0d ctrl got=%b exp=%b", c, {rd_en4, wr_en4, done4, busy4}, exp_ctrl);
      end
      got_rd = pk(10'(rd_a4), 10'(rd_b4), 10'(tw4));
      exp_rd = 32'd0;
      if (m_rd[c] != 0 && exp_q.size() > 0) exp_rd = exp_q.pop_front();
      n_cmp++;
      if (got_rd !== exp_rd) begin
        n_err++;
        $display("FAIL n4 c=%0d rd{a,b,tw} got=%h exp=%h", c, got_rd, exp_rd);
      end
      n_cmp++;
      if ({10'(wr_a4), 10'(wr_b4), 4'(stage4)} !== {10'(m_wa[c]), 10'(m_wb[c]), 4'(m_stage[c])}) begin
        n_err++;
        $display("FAIL n4 c=%0d wr/stage got=%0d,%0d,%0d exp=%0d,%0d,%0d", c, wr_a4, wr_b4, stage4,
                 m_wa[c], m_wb[c], m_stage[c]);
      end
`ifdef FFT_CTRL_SCALE_EN
      n_cmp++;
      if (scale4 !== wr_en4 || scale4 !== (m_wr[c] != 0)) begin
        n_err++;
        $display("FAIL n4 c=%0d scale_en got=%b exp=%0d", c, scale4, m_wr[c]);
      end
`endif
    end
    n_cmp++;
    if (exp_q.size() != 0 || state4 !== IDLE) begin
      n_err++;
      $display("FAIL n4 end reads_left=%0d state=%0d exp 0,%0d", exp_q.size(), state4, IDLE);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_n8();
    test_back_to_back();
    test_rst_mid();
    test_random();
    test_n4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
